// File: rtl/execute_dp.sv
// Execute stage for ARM data-processing instructions.
// Consumes decode bundles on a level-ready / toggle-trigger handshake, computes
// the shifter operand, condition, ALU result and NZCV. Results go to the
// register bank over the same toggle/ready protocol.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for synchronised readyIn, then latch the bundle
// EXEC    | evaluate condition/shifter/ALU, register result and flags
// WB_REQ  | toggle triggerOutRB to request a register write
// WB_LOW  | wait for synchronised readyInRB to drop
// WB_HIGH | wait for synchronised readyInRB to rise (write done)
// ACK     | toggle triggerOut, count retired instruction
// DRAIN   | wait for readyIn to fall so a bundle is never reused
module execute_dp #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      dataIn1,
    input  logic [31:0]      dataIn2,
    input  logic [31:0]      dataIn3,
    input  logic [31:0]      dataIn4,
    input  logic [3:0]       typeIn,
    input  logic             readyIn,
    output logic             triggerOut,
    output logic [3:0]       wrAddrRB,
    output logic [31:0]      wrDataRB,
    output logic             triggerOutRB,
    input  logic             readyInRB,
    output logic [3:0]       flagsOut,
    output logic [CNT_W-1:0] retiredCount
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] EXEC    = 3'd1;
    localparam logic [2:0] WB_REQ  = 3'd2;
    localparam logic [2:0] WB_LOW  = 3'd3;
    localparam logic [2:0] WB_HIGH = 3'd4;
    localparam logic [2:0] ACK     = 3'd5;
    localparam logic [2:0] DRAIN   = 3'd6;

    logic [2:0]             state;
    logic [SYNC_STAGES-1:0] rdy_sync;
    logic [SYNC_STAGES-1:0] rbrdy_sync;
    logic                   rdy_s;
    logic                   rbrdy_s;
    logic [31:0]            op1;
    logic [31:0]            op2;
    logic [31:0]            inst;
    logic [3:0]             typ;
    logic                   passed;

    logic                   flag_n, flag_z, flag_c, flag_v;
    logic [3:0]             opcode;
    logic [4:0]             amt;
    logic [4:0]             rot;
    logic [32:0]            lsl33;
    logic [32:0]            rsh33;
    logic [32:0]            asr33;
    logic [31:0]            sh_val;
    logic                   sh_c;
    logic                   cond_pass;
    logic [31:0]            alu_a;
    logic [31:0]            alu_b;
    logic                   alu_cin;
    logic                   is_arith;
    logic [32:0]            sum;
    logic [31:0]            result;
    logic [3:0]             new_flags;
    logic                   dp_ok;
    logic                   do_wb;
    logic                   unused_bits;

    assign rdy_s   = rdy_sync[SYNC_STAGES-1];
    assign rbrdy_s = rbrdy_sync[SYNC_STAGES-1];
    assign {flag_n, flag_z, flag_c, flag_v} = flagsOut;
    assign opcode = inst[24:21];
    assign amt    = inst[11:7];
    assign rot    = {inst[11:8], 1'b0};
    assign unused_bits = ^{dataIn3, inst[27:26], inst[19:16], inst[3:0]};

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
        return (x >> r) | (x << (6'd32 - {1'b0, r}));
    endfunction

    // Two-flop (or deeper) synchronisers for the asynchronous ready levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_sync   <= '0;
            rbrdy_sync <= '0;
        end else begin
            rdy_sync   <= {rdy_sync[SYNC_STAGES-2:0], readyIn};
            rbrdy_sync <= {rbrdy_sync[SYNC_STAGES-2:0], readyInRB};
        end
    end

    assign lsl33 = {1'b0, op2} << amt;
    assign rsh33 = {op2, 1'b0} >> amt;
    assign asr33 = 33'($signed({op2, 1'b0}) >>> amt);

    // Shifter operand and its carry-out; register-specified shifts fall back to LSL #0
    always_comb begin
        sh_val = op2;
        sh_c   = flag_c;
        if (inst[25]) begin
            sh_val = ror32(op2, rot);
            sh_c   = (rot == 5'd0) ? flag_c : sh_val[31];
        end else if (!inst[4]) begin
            case (inst[6:5])
                2'b00: begin
                    if (amt != 5'd0) {sh_c, sh_val} = lsl33;
                end
                2'b01: begin
                    if (amt == 5'd0) begin
                        sh_val = '0;
                        sh_c   = op2[31];
                    end else begin
                        sh_val = rsh33[32:1];
                        sh_c   = rsh33[0];
                    end
                end
                2'b10: begin
                    if (amt == 5'd0) begin
                        sh_val = {32{op2[31]}};
                        sh_c   = op2[31];
                    end else begin
                        sh_val = asr33[32:1];
                        sh_c   = asr33[0];
                    end
                end
                default: begin
                    if (amt == 5'd0) begin
                        sh_val = {flag_c, op2[31:1]};
                        sh_c   = op2[0];
                    end else begin
                        sh_val = ror32(op2, amt);
                        sh_c   = sh_val[31];
                    end
                end
            endcase
        end
    end

    // Condition field against the current flags; 1111 never executes
    always_comb begin
        cond_pass = 1'b0;
        case (inst[31:28])
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Adder operand selection: subtracts are a + ~b + carry so C is NOT borrow
    always_comb begin
        alu_a    = op1;
        alu_b    = sh_val;
        alu_cin  = 1'b0;
        is_arith = 1'b1;
        case (opcode)
            4'h2, 4'hA: begin alu_b = ~sh_val; alu_cin = 1'b1; end
            4'h3:       begin alu_a = sh_val; alu_b = ~op1; alu_cin = 1'b1; end
            4'h4, 4'hB: alu_cin = 1'b0;
            4'h5:       alu_cin = flag_c;
            4'h6:       begin alu_b = ~sh_val; alu_cin = flag_c; end
            4'h7:       begin alu_a = sh_val; alu_b = ~op1; alu_cin = flag_c; end
            default:    is_arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};

    // ALU result and the NZCV it would produce
    always_comb begin
        result = sum[31:0];
        case (opcode)
            4'h0, 4'h8: result = op1 & sh_val;
            4'h1, 4'h9: result = op1 ^ sh_val;
            4'hC:       result = op1 | sh_val;
            4'hD:       result = sh_val;
            4'hE:       result = op1 & ~sh_val;
            4'hF:       result = ~sh_val;
            default:    result = sum[31:0];
        endcase
        new_flags[3] = result[31];
        new_flags[2] = (result == 32'd0);
        new_flags[1] = is_arith ? sum[32] : sh_c;
        new_flags[0] = is_arith ? ((alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31])) : flag_v;
    end

    assign dp_ok = (typ == 4'd0) && cond_pass;
    assign do_wb = dp_ok && (opcode[3:2] != 2'b10);

    // Sequencer: bundle intake, execute, writeback handshake, acknowledge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op1          <= '0;
            op2          <= '0;
            inst         <= '0;
            typ          <= '0;
            passed       <= 1'b0;
            triggerOut   <= 1'b0;
            triggerOutRB <= 1'b0;
            wrAddrRB     <= '0;
            wrDataRB     <= '0;
            flagsOut     <= '0;
            retiredCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rdy_s) begin
                        op1   <= dataIn1;
                        op2   <= dataIn2;
                        inst  <= dataIn4;
                        typ   <= typeIn;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    passed <= dp_ok;
                    if (dp_ok && inst[20]) flagsOut <= new_flags;
                    if (do_wb) begin
                        wrAddrRB <= inst[15:12];
                        wrDataRB <= result;
                        state    <= WB_REQ;
                    end else begin
                        state <= ACK;
                    end
                end
                WB_REQ: begin
                    triggerOutRB <= ~triggerOutRB;
                    state        <= WB_LOW;
                end
                WB_LOW: begin
                    if (!rbrdy_s) state <= WB_HIGH;
                end
                WB_HIGH: begin
                    if (rbrdy_s) state <= ACK;
                end
                ACK: begin
                    triggerOut <= ~triggerOut;
                    if (passed) retiredCount <= retiredCount + CNT_W'(1);
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!rdy_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_dp.sv
// Scoreboard bench for execute_dp: a behavioural ARM data-processing model
// predicts each bundle's writeback and flags; a monitor checks DUT outputs.
module tb_execute_dp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dataIn1 = '0, dataIn2 = '0, dataIn3 = '0, dataIn4 = '0;
    logic [3:0]  typeIn = '0;
    logic        readyIn = 1'b0;
    logic        triggerOut;
    logic [3:0]  wrAddrRB;
    logic [31:0] wrDataRB;
    logic        triggerOutRB;
    logic        readyInRB = 1'b1;
    logic [3:0]  flagsOut;
    logic [31:0] retiredCount;

    execute_dp #(.SYNC_STAGES(2), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .dataIn1(dataIn1), .dataIn2(dataIn2), .dataIn3(dataIn3), .dataIn4(dataIn4),
        .typeIn(typeIn), .readyIn(readyIn), .triggerOut(triggerOut),
        .wrAddrRB(wrAddrRB), .wrDataRB(wrDataRB), .triggerOutRB(triggerOutRB),
        .readyInRB(readyInRB), .flagsOut(flagsOut), .retiredCount(retiredCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wb;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  flags;
        logic [31:0] retired;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          ack_count = 0;
    int          wb_count = 0;
    bit          wb_seen = 0;
    bit          mon_en = 0;
    bit          bank_stall = 0;
    logic        prev_t = 1'b0, prev_rb = 1'b0, bank_prev = 1'b0;
    logic [3:0]  m_flags = '0;
    logic [31:0] m_retired = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference shifter operand, written from the ARM addressing-mode rules
    function automatic void ref_shift(input logic [31:0] b, input logic [31:0] ins, input bit cin,
                                      output logic [31:0] v, output bit c);
        int n;
        longint sb;
        if (ins[25]) begin
            n = 2 * int'(ins[11:8]);
            v = (b >> n) | (b << (32 - n));
            c = (n == 0) ? cin : v[31];
        end else if (ins[4]) begin
            v = b; c = cin;
        end else begin
            n = int'(ins[11:7]);
            case (ins[6:5])
                2'd0: if (n == 0) begin v = b; c = cin; end
                      else begin v = b << n; c = b[32 - n]; end
                2'd1: begin if (n == 0) n = 32; v = b >> n; c = b[n - 1]; end
                2'd2: begin
                    if (n == 0) n = 32;
                    sb = longint'(signed'(b));
                    sb = sb >>> n;
                    v = sb[31:0]; c = b[n - 1];
                end
                default: if (n == 0) begin v = {cin, b[31:1]}; c = b[0]; end
                         else begin v = (b >> n) | (b << (32 - n)); c = b[n - 1]; end
            endcase
        end
    endfunction

    // Reference instruction model: plain 64-bit arithmetic on unsigned/signed values
    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] ins, input logic [3:0] typ);
        exp_t e;
        bit n, z, c, v, pass, sc, nc, nv;
        logic [31:0] s, r;
        longint x, y, sx, sy, ur, sr, k;
        bit arith, is_sub;
        {n, z, c, v} = m_flags;
        case (ins[31:28])
            4'h0: pass = z;          4'h1: pass = !z;
            4'h2: pass = c;          4'h3: pass = !c;
            4'h4: pass = n;          4'h5: pass = !n;
            4'h6: pass = v;          4'h7: pass = !v;
            4'h8: pass = c && !z;    4'h9: pass = !c || z;
            4'hA: pass = n == v;     4'hB: pass = n != v;
            4'hC: pass = !z && n == v;
            4'hD: pass = z || n != v;
            4'hE: pass = 1;
            default: pass = 0;
        endcase
        if (typ != 0) pass = 0;
        ref_shift(b, ins, c, s, sc);
        arith = 1; is_sub = 0; k = 0;
        x = longint'(a); y = longint'(s);
        sx = longint'(signed'(a)); sy = longint'(signed'(s));
        r = '0;
        case (ins[24:21])
            4'h0, 4'h8: begin arith = 0; r = a & s; end
            4'h1, 4'h9: begin arith = 0; r = a ^ s; end
            4'hC: begin arith = 0; r = a | s; end
            4'hD: begin arith = 0; r = s; end
            4'hE: begin arith = 0; r = a & ~s; end
            4'hF: begin arith = 0; r = ~s; end
            4'h2, 4'hA: is_sub = 1;
            4'h3: begin is_sub = 1; x = longint'(s); y = longint'(a);
                        sx = longint'(signed'(s)); sy = longint'(signed'(a)); end
            4'h4, 4'hB: k = 0;
            4'h5: k = c;
            4'h6: begin is_sub = 1; k = !c; end
            default: begin is_sub = 1; k = !c; x = longint'(s); y = longint'(a);
                           sx = longint'(signed'(s)); sy = longint'(signed'(a)); end
        endcase
        nc = sc; nv = v;
        if (arith) begin
            if (is_sub) begin
                ur = x - y - k; sr = sx - sy - k; nc = (ur >= 0);
            end else begin
                ur = x + y + k; sr = sx + sy + k; nc = (ur > 64'sh0FFFFFFFF);
            end
            r = ur[31:0];
            nv = (sr != longint'(signed'(r)));
        end
        if (pass && ins[20]) m_flags = {r[31], r == 0, nc, nv};
        if (pass) m_retired = m_retired + 1;
        e.wb = pass && !(ins[24:21] inside {4'h8, 4'h9, 4'hA, 4'hB});
        e.addr = ins[15:12];
        e.data = r;
        e.flags = m_flags;
        e.retired = m_retired;
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT toggles one of its triggers
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (triggerOutRB != prev_rb) begin
                wb_count++;
                wb_seen = 1;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL wb_unexpected: got RB toggle expected none");
                end else begin
                    chk("wb_expected", 32'(exp_q[0].wb), 32'd1);
                    chk("wb_addr", 32'(wrAddrRB), 32'(exp_q[0].addr));
                    chk("wb_data", wrDataRB, exp_q[0].data);
                end
            end
            if (triggerOut != prev_t) begin
                ack_count++;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL ack_unexpected: got ack toggle expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_wb_seen", 32'(wb_seen), 32'(e.wb));
                    chk("ack_flags", 32'(flagsOut), 32'(e.flags));
                    chk("ack_retired", retiredCount, e.retired);
                    if (e.wb) chk("ack_wb_data_held", wrDataRB, e.data);
                end
                wb_seen = 0;
            end
        end
        prev_rb = triggerOutRB;
        prev_t  = triggerOut;
    end

    // Register bank responder: drops then raises readyInRB after each request
    initial begin
        forever begin
            @(negedge clk);
            if (triggerOutRB != bank_prev) begin
                bank_prev = triggerOutRB;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                readyInRB = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                while (bank_stall) @(negedge clk);
                readyInRB = 1'b1;
            end
        end
    end

    task automatic issue(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] ins,
                         input logic [3:0] typ, input int hold);
        logic start;
        bit got;
        exp_q.push_back(ref_model(d1, d2, ins, typ));
        @(negedge clk);
        dataIn1 = d1; dataIn2 = d2; dataIn3 = $urandom; dataIn4 = ins; typeIn = typ;
        readyIn = 1'b1;
        start = triggerOut;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (triggerOut != start) got = 1;
        end
        chk("ack_timeout", 32'(got), 32'd1);
        repeat (hold) @(negedge clk);
        readyIn = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int a0, w0;
        logic [31:0] r0, ins, d1, d2;
        logic [3:0] cond, typ;
        bit imm, got;
        logic start;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_trig", 32'(triggerOut), 32'd0);
        chk("rst_trig_rb", 32'(triggerOutRB), 32'd0);
        chk("rst_wraddr", 32'(wrAddrRB), 32'd0);
        chk("rst_wrdata", wrDataRB, 32'd0);
        chk("rst_flags", 32'(flagsOut), 32'd0);
        chk("rst_retired", retiredCount, 32'd0);
        reset = 1'b0;
        mon_en = 1;
        repeat (2) @(negedge clk);

        // ADDS R0,R1,R2 overflowing into the sign bit
        a0 = ack_count; w0 = wb_count;
        issue(32'h7FFFFFFF, 32'h1, 32'hE0910002, 4'd0, 0);
        chk("adds_wraddr", 32'(wrAddrRB), 32'd0);
        chk("adds_wrdata", wrDataRB, 32'h80000000);
        chk("adds_flags", 32'(flagsOut), 32'h9);
        chk("adds_retired", retiredCount, 32'd1);
        chk("adds_rb_toggles", 32'(wb_count - w0), 32'd1);
        chk("adds_acks", 32'(ack_count - a0), 32'd1);

        // SUBS equal operands, then MOVNE must be skipped
        issue(32'd5, 32'd5, 32'hE0510002, 4'd0, 0);
        chk("subs_flags", 32'(flagsOut), 32'h6);
        a0 = ack_count; w0 = wb_count; r0 = retiredCount;
        issue(32'd0, 32'd1, 32'h13A01001, 4'd0, 0);
        chk("movne_rb_toggles", 32'(wb_count - w0), 32'd0);
        chk("movne_acks", 32'(ack_count - a0), 32'd1);
        chk("movne_retired", retiredCount, r0);

        // MOVS with rotated immediate, then LSR #0 meaning LSR #32
        issue(32'd0, 32'hFF, 32'hE3B004FF, 4'd0, 0);
        chk("movs_imm_data", wrDataRB, 32'hFF000000);
        chk("movs_imm_flags", 32'(flagsOut), 32'hA);
        issue(32'd0, 32'h80000001, 32'hE1B00022, 4'd0, 0);
        chk("lsr32_data", wrDataRB, 32'h0);
        chk("lsr32_flags", 32'(flagsOut), 32'h6);

        // CMP 3,4: flags only
        w0 = wb_count;
        issue(32'd3, 32'd4, 32'hE1500001, 4'd0, 0);
        chk("cmp_flags", 32'(flagsOut), 32'h8);
        chk("cmp_rb_toggles", 32'(wb_count - w0), 32'd0);

        // readyIn held high across ACK: exactly one consume until it re-rises
        a0 = ack_count;
        issue(32'd1, 32'd2, 32'hE0810002, 4'd0, 25);
        chk("hold_one_ack", 32'(ack_count - a0), 32'd1);
        issue(32'd1, 32'd2, 32'hE0810002, 4'd0, 0);
        chk("rerise_second_ack", 32'(ack_count - a0), 32'd2);

        // Non data-processing class: ack only
        a0 = ack_count; w0 = wb_count;
        issue(32'd9, 32'd9, 32'hE0910002, 4'd3, 0);
        chk("type3_rb_toggles", 32'(wb_count - w0), 32'd0);
        chk("type3_acks", 32'(ack_count - a0), 32'd1);

        // Randomized instructions
        for (int t = 0; t < 300; t++) begin
            cond = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
            imm  = 1'($urandom_range(0, 1));
            ins  = {cond, 2'b00, imm, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095))};
            case ($urandom_range(0, 3))
                0: d1 = 32'h7FFFFFFF;
                1: d1 = 32'h80000000;
                default: d1 = $urandom;
            endcase
            d2 = imm ? {24'd0, ins[7:0]} : (($urandom_range(0, 4) == 0) ? d1 : $urandom);
            typ = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            issue(d1, d2, ins, typ, $urandom_range(0, 3));
        end
        repeat (10) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while waiting in WB_HIGH aborts the writeback
        mon_en = 0;
        bank_stall = 1;
        @(negedge clk);
        dataIn1 = 32'd1; dataIn2 = 32'd2; dataIn4 = 32'hE0810002; typeIn = 4'd0;
        readyIn = 1'b1;
        start = triggerOutRB;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (triggerOutRB != start) got = 1;
        end
        chk("wbh_req_seen", 32'(got), 32'd1);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        readyIn = 1'b0;
        @(negedge clk);
        chk("mid_rst_trig", 32'(triggerOut), 32'd0);
        chk("mid_rst_trig_rb", 32'(triggerOutRB), 32'd0);
        chk("mid_rst_wraddr", 32'(wrAddrRB), 32'd0);
        chk("mid_rst_wrdata", wrDataRB, 32'd0);
        chk("mid_rst_flags", 32'(flagsOut), 32'd0);
        chk("mid_rst_retired", retiredCount, 32'd0);
        exp_q.delete();
        m_flags = '0;
        m_retired = '0;
        @(negedge clk);
        reset = 1'b0;
        bank_stall = 0;
        repeat (30) @(negedge clk);
        chk("post_rst_no_rb", 32'(triggerOutRB), 32'd0);
        chk("post_rst_no_ack", 32'(triggerOut), 32'd0);
        chk("post_rst_retired", retiredCount, 32'd0);
        mon_en = 1;

        // Normal operation resumes after reset
        issue(32'h7FFFFFFF, 32'h1, 32'hE0910002, 4'd0, 0);
        chk("resume_retired", retiredCount, 32'd1);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_dp.md
Name: execute_dp

Overview:
Execute stage directly downstream of the decode stage. It consumes decode's operand/instruction bundle under decode's level-ready / toggle-trigger handshake and completes ARM data-processing instructions. Each instruction gets its shifter operand, condition check, ALU operation and NZCV update. Results are written back to the register bank over the same toggle/ready protocol. Unlike decode, this block is synchronous: one clock, with asynchronous inputs synchronised on entry.

Parameters:
SYNC_STAGES, 2, flip-flop depth of synchronisers on readyIn and readyInRB (min 2)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  stage clock
reset  input  1  asynchronous, active-high reset
dataIn1  input  32  operand1 (Rn value) from decode
dataIn2  input  32  operand2 from decode: Rm value (I=0) or zero-extended imm8 (I=1)
dataIn3  input  32  reserved, ignored
dataIn4  input  32  original instruction word
typeIn  input  4  instruction class; 0 = data processing
readyIn  input  1  decode bundle valid (level, asynchronous)
triggerOut  output  1  toggles once per consumed bundle; drives decode triggerIn
wrAddrRB  output  4  writeback register number
wrDataRB  output  32  writeback value
triggerOutRB  output  1  toggles once per writeback request
readyInRB  input  1  register bank done (level, asynchronous)
flagsOut  output  4  NZCV (bit3 = N)
retiredCount  output  CNT_W  count of condition-passed instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset: state IDLE. All outputs are 0, including both toggle levels, flagsOut, wrAddrRB, wrDataRB and retiredCount. Synchronisers are cleared. Reset mid-operation aborts the operation; there is no partial writeback or flag update after reset release.
- Notation: rdy_s and rbrdy_s are the synchronised readyIn and readyInRB. inst = latched dataIn4.
- IDLE: when rdy_s==1, latch dataIn1/2/4 and typeIn, then go to EXEC. Raw readyIn to latch is SYNC_STAGES+1 edges.
- EXEC, one cycle: compute the result and flags, then register them.
  - typeIn!=0: NOP. Go to ACK.
  - Condition inst[31:28] evaluated on current flagsOut using the ARM EQ..AL table; 1111 = never. If the condition fails: NOP, go to ACK.
  - S=0 with opcode TST/TEQ/CMP/CMN: NOP.
- Shifter operand, I=1: imm8 is rotated right by 2*inst[11:8]. Carry-out = C when rot==0, else result[31].
- Shifter operand, I=0 with inst[4]==0 (immediate shift): amount inst[11:7], type inst[6:5].
  - LSL #0 passes the value with carry C.
  - LSR #0 means LSR #32: result 0, carry Rm[31].
  - ASR #0 means ASR #32: result replicates Rm[31], carry Rm[31].
  - ROR #0 means RRX: {C,Rm[31:1]}, carry Rm[0].
- Shifter operand, I=0 with inst[4]==1 (register-specified shift): unsupported. Treated as LSL #0.
- ALU: all 16 opcodes per inst[24:21]. Adds and subtracts use 33-bit arithmetic.
  - C = carry-out for ADD/ADC/CMN, NOT borrow for SUB/SBC/RSB/RSC/CMP.
  - V = signed overflow.
  - Logical ops: C = shifter carry, V unchanged.
  - N = result[31], Z = (result==0).
  - Flags update only if S=1 and the condition passed.
- Writeback: opcodes 1000-1011 have no writeback; all others write Rd=inst[15:12]. Rd=15 is written like any register, with no SPSR copy.
- Writeback needed: wrAddrRB and wrDataRB are set in EXEC.
  - Go to WB_REQ: toggle triggerOutRB.
  - WB_LOW: wait rbrdy_s==0.
  - WB_HIGH: wait rbrdy_s==1.
  - Then go to ACK.
  - wrAddrRB and wrDataRB are held stable from WB_REQ until WB_HIGH exits.
- ACK: toggle triggerOut, increment retiredCount if the condition passed, go to DRAIN.
- DRAIN: wait rdy_s==0, then IDLE. This prevents the same bundle being consumed twice. A bundle is never consumed while rdy_s is still high from the previous one.
- Flags written in EXEC are visible to the condition check of the next instruction; back-to-back dependency is safe.
- Simultaneous readyIn rise and reset: reset wins.
- readyInRB toggling outside WB_*: ignored.

Test Plan:
- Reset: assert reset mid-WB_HIGH -> all outputs 0, state IDLE; no later RB toggle.
- ADDS: flags 0, op1=0x7FFFFFFF, op2=1, inst=0xE0910002 -> wrAddrRB=0, wrDataRB=0x80000000, NZCV=1001, triggerOutRB toggles once, then triggerOut toggles once, retiredCount=1.
- SUBS then BEQ-style condition: SUBS op1=5, op2=5 -> Z=1, C=1. Next MOVNE (inst 0x13A01001) -> no RB toggle, triggerOut toggles, retiredCount unchanged.
- Immediate rotate: MOVS inst=0xE3B004FF -> result 0xFF000000, N=1, C=1. Shifter LSR #0 on Rm=0x80000001 -> result 0, C=1.
- CMP (inst 0xE1500001), op1=3, op2=4 -> NZCV=1000, no writeback, triggerOut toggles.
- Handshake: hold readyIn high across ACK -> exactly one triggerOut toggle until readyIn falls and re-rises; typeIn=3 -> ACK only, no RB activity.
